// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types, ALU opcodes and instruction field positions for alu_control_fsm
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU_RR  = 2'b00,
        CLS_ALU_RI  = 2'b01,
        CLS_BEQ     = 2'b10,
        CLS_SPECIAL = 2'b11
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_BIC = 3'b101;
    localparam logic [2:0] ALU_RSB = 3'b110;
    localparam logic [2:0] ALU_BEQ = 3'b111;

    // op 111 in class 11 is HALT when the halt feature is built in
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int CLS_HI = 15;
    localparam int CLS_LO = 14;
    localparam int OP_HI  = 13;
    localparam int OP_LO  = 11;
    localparam int RD_HI  = 10;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 7;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/alu_control_fsm_if.sv
// rtl/alu_control_fsm_if.sv - instruction memory req/ack fetch interface
interface alu_control_fsm_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ctrl_instr_decode.sv
// rtl/ctrl_instr_decode.sv - combinational field split and class decode of the latched instruction
module ctrl_instr_decode
    import ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output cls_t        cls,
    output logic [2:0]  op,
    output logic [1:0]  rd,
    output logic [1:0]  rs,
    output logic [7:0]  imm,
    output logic [2:0]  alu_op,
    output logic        use_imm
);

    assign cls = cls_t'(instr[CLS_HI:CLS_LO]);
    assign op  = instr[OP_HI:OP_LO];
    assign rd  = instr[RD_HI:RD_LO];
    assign rs  = instr[RS_HI:RS_LO];
    assign imm = instr[IMM_HI:IMM_LO];

    // branches always drive the compare opcode regardless of the op field
    assign alu_op  = (cls == CLS_BEQ) ? ALU_BEQ : op;
    assign use_imm = (cls == CLS_ALU_RI);

endmodule

// File: rtl/alu_control_fsm.sv
// rtl/alu_control_fsm.sv - multi-cycle fetch/decode/execute/writeback control unit; optional HALT via CTRL_HALT_EN
module alu_control_fsm
    import ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
)(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_control_fsm_if.master    bus,
    output logic [2:0]           alu_control,
    output logic                 alu_b_sel,
    output logic [7:0]           imm_out,
    output logic [1:0]           rf_raddr_a,
    output logic [1:0]           rf_raddr_b,
    output logic [1:0]           rf_waddr,
    output logic                 rf_we,
    input  logic                 equality,
    output logic                 halted
);

    state_t          state, next_state;
    logic [PC_W-1:0] pc, next_pc;
    logic [15:0]     instr;
    logic            req_q, next_req;

    cls_t            cls;
    logic [2:0]      op;
    logic [1:0]      rd;
    logic [1:0]      rs;
    logic [7:0]      imm;
    logic [2:0]      alu_op;
    logic            use_imm;
    logic            is_halt;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_branch;
    logic            fetch_done;

    ctrl_instr_decode u_decode (
        .instr   (instr),
        .cls     (cls),
        .op      (op),
        .rd      (rd),
        .rs      (rs),
        .imm     (imm),
        .alu_op  (alu_op),
        .use_imm (use_imm)
    );

`ifdef CTRL_HALT_EN
    assign is_halt = (cls == CLS_SPECIAL) && (op == OP_HALT);
    assign halted  = (state == ST_HALT);
`else
    assign is_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    // request is registered so it stays low during reset and rises one cycle after release
    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc;
    assign imm_out       = imm;

    // only an ack against an outstanding request completes a fetch
    assign fetch_done = (state == ST_FETCH) && req_q && bus.imem_ack;

    // PC arithmetic wraps modulo 2^PC_W; the offset is sign-extended from imm
    assign pc_inc    = pc + PC_W'(1);
    assign pc_branch = pc_inc + PC_W'($signed(imm));

    // state, PC, request flag and latched instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            instr <= '0;
            req_q <= 1'b0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            req_q <= next_req;
            if (fetch_done) begin
                instr <= bus.imem_rdata;
            end
        end
    end

    // next-state, next-PC and per-state datapath controls
    always_comb begin
        next_state  = state;
        next_pc     = pc;
        next_req    = 1'b0;
        alu_control = ALU_ADD;
        alu_b_sel   = 1'b0;
        rf_raddr_a  = 2'b00;
        rf_raddr_b  = 2'b00;
        rf_waddr    = 2'b00;
        rf_we       = 1'b0;

        case (state)
            ST_FETCH: begin
                if (fetch_done) begin
                    next_state = ST_DECODE;
                end else begin
                    next_req = 1'b1;
                end
            end

            ST_DECODE: begin
                rf_raddr_a = rd;
                rf_raddr_b = rs;
                if (is_halt) begin
                    next_state = ST_HALT;
                end else if (cls == CLS_SPECIAL) begin
                    next_pc    = pc_inc;
                    next_state = ST_FETCH;
                    next_req   = 1'b1;
                end else begin
                    next_state = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                alu_control = alu_op;
                alu_b_sel   = use_imm;
                rf_raddr_a  = rd;
                rf_raddr_b  = rs;
                if (cls == CLS_BEQ) begin
                    next_pc    = equality ? pc_branch : pc_inc;
                    next_state = ST_FETCH;
                    next_req   = 1'b1;
                end else if (op == ALU_BEQ) begin
                    // compare-only ALU op: no register write
                    next_pc    = pc_inc;
                    next_state = ST_FETCH;
                    next_req   = 1'b1;
                end else begin
                    next_state = ST_WRITEBACK;
                end
            end

            ST_WRITEBACK: begin
                alu_control = alu_op;
                alu_b_sel   = use_imm;
                rf_raddr_a  = rd;
                rf_raddr_b  = rs;
                rf_waddr    = rd;
                rf_we       = 1'b1;
                next_pc     = pc_inc;
                next_state  = ST_FETCH;
                next_req    = 1'b1;
            end

            ST_HALT: begin
                next_state = ST_HALT;
            end

            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_control_fsm.sv
// tb/tb_alu_control_fsm.sv - directed self-checking bench for alu_control_fsm
module tb_alu_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [2:0] alu_control;
    logic       alu_b_sel;
    logic [7:0] imm_out;
    logic [1:0] rf_raddr_a;
    logic [1:0] rf_raddr_b;
    logic [1:0] rf_waddr;
    logic       rf_we;
    logic       equality;
    logic       halted;

    int checks = 0;
    int errors = 0;

    alu_control_fsm_if #(.PC_W(8)) imem ();

    alu_control_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (imem),
        .alu_control (alu_control),
        .alu_b_sel   (alu_b_sel),
        .imm_out     (imm_out),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_waddr    (rf_waddr),
        .rf_we       (rf_we),
        .equality    (equality),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // wait (bounded) for an outstanding fetch request
    task automatic wait_req();
        int n = 0;
        while (imem.imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", {15'd0, imem.imem_req}, 16'd1);
    endtask

    // serve one fetch with 'delay' wait cycles; returns at the DECODE-cycle negedge
    task automatic do_fetch(input logic [15:0] ins, input int delay, input logic [7:0] exp_pc);
        wait_req();
        chk("fetch_addr", {8'd0, imem.imem_addr}, {8'd0, exp_pc});
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("req_held", {15'd0, imem.imem_req}, 16'd1);
            chk("addr_stable", {8'd0, imem.imem_addr}, {8'd0, exp_pc});
        end
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = ins;
        @(negedge clk);
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 16'h0000;
        chk("req_drop", {15'd0, imem.imem_req}, 16'd0);
    endtask

    // BEQ with given offset and equality; returns at the following FETCH negedge
    task automatic do_beq(input logic [7:0] pc, input logic [7:0] off, input logic eq);
        do_fetch({8'h80, off}, 0, pc);
        @(negedge clk);
        equality = eq;
        chk("beq_alu", {13'd0, alu_control}, 16'h0007);
        chk("beq_we", {15'd0, rf_we}, 16'd0);
        @(negedge clk);
        equality = 1'b0;
        chk("beq_we_after", {15'd0, rf_we}, 16'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        equality        = 1'b0;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 16'h0000;

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {15'd0, imem.imem_req}, 16'd0);
        chk("rst_we", {15'd0, rf_we}, 16'd0);
        chk("rst_alu", {13'd0, alu_control}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_addr", {8'd0, imem.imem_addr}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_after_rst", {15'd0, imem.imem_req}, 16'd1);

        // ADD r1,r2 with same-cycle ack
        do_fetch(16'h0300, 0, 8'h00);
        chk("add_raddr_a", {14'd0, rf_raddr_a}, 16'd1);
        chk("add_raddr_b", {14'd0, rf_raddr_b}, 16'd2);
        chk("add_dec_alu", {13'd0, alu_control}, 16'd0);
        @(negedge clk);
        chk("add_ex_alu", {13'd0, alu_control}, 16'd0);
        chk("add_ex_bsel", {15'd0, alu_b_sel}, 16'd0);
        chk("add_ex_we", {15'd0, rf_we}, 16'd0);
        @(negedge clk);
        chk("add_wb_we", {15'd0, rf_we}, 16'd1);
        chk("add_wb_waddr", {14'd0, rf_waddr}, 16'd1);
        @(negedge clk);
        chk("add_next_we", {15'd0, rf_we}, 16'd0);
        chk("add_next_req", {15'd0, imem.imem_req}, 16'd1);
        chk("add_pc", {8'd0, imem.imem_addr}, 16'h0001);

        // reset asserted mid-WRITEBACK
        do_fetch(16'h0300, 0, 8'h01);
        @(negedge clk);
        @(negedge clk);
        chk("wb2_we", {15'd0, rf_we}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_we", {15'd0, rf_we}, 16'd0);
        chk("midrst_req", {15'd0, imem.imem_req}, 16'd0);
        chk("midrst_pc", {8'd0, imem.imem_addr}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_req_back", {15'd0, imem.imem_req}, 16'd1);

        // SUB r2,#5 with 3 wait cycles
        do_fetch(16'h4C05, 3, 8'h00);
        chk("sub_dec_we", {15'd0, rf_we}, 16'd0);
        @(negedge clk);
        chk("sub_ex_alu", {13'd0, alu_control}, 16'h0001);
        chk("sub_ex_bsel", {15'd0, alu_b_sel}, 16'd1);
        chk("sub_imm", {8'd0, imm_out}, 16'h0005);
        chk("sub_ex_we", {15'd0, rf_we}, 16'd0);
        @(negedge clk);
        chk("sub_wb_we", {15'd0, rf_we}, 16'd1);
        chk("sub_wb_waddr", {14'd0, rf_waddr}, 16'd2);
        chk("sub_wb_bsel", {15'd0, alu_b_sel}, 16'd1);
        @(negedge clk);
        chk("sub_after_we", {15'd0, rf_we}, 16'd0);

        // advance pc 1 -> 0x10 with NOPs
        for (int p = 1; p < 16; p++) begin
            do_fetch(16'hC000, 0, 8'(p));
        end

        // branches, including wrap-around in both directions
        do_beq(8'h10, 8'hFE, 1'b1);
        do_fetch(16'hC000, 0, 8'h0F);
        do_beq(8'h10, 8'hFE, 1'b0);
        do_beq(8'h11, 8'hED, 1'b1);
        do_fetch(16'hC000, 0, 8'hFF);
        do_beq(8'h00, 8'hFE, 1'b1);
        do_beq(8'hFF, 8'h01, 1'b1);

        // compare-only ALU op; stray ack during DECODE ignored
        do_fetch(16'h3800, 0, 8'h01);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 16'hFFFF;
        @(negedge clk);
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 16'h0000;
        chk("cmp_alu", {13'd0, alu_control}, 16'h0007);
        chk("cmp_we", {15'd0, rf_we}, 16'd0);
        @(negedge clk);
        chk("cmp_no_wb", {15'd0, rf_we}, 16'd0);

        // HALT encoding
        do_fetch(16'hF800, 0, 8'h02);
`ifdef CTRL_HALT_EN
        @(negedge clk);
        chk("halt_flag", {15'd0, halted}, 16'd1);
        chk("halt_req", {15'd0, imem.imem_req}, 16'd0);
        repeat (4) @(negedge clk);
        chk("halt_req_stays", {15'd0, imem.imem_req}, 16'd0);
        chk("halt_flag_stays", {15'd0, halted}, 16'd1);
`else
        wait_req();
        chk("nop_halt_pc", {8'd0, imem.imem_addr}, 16'h0003);
        chk("nop_halted", {15'd0, halted}, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
